// File: rtl/spc_pcx_req_issue.sv
// Core-side PCX request issuer: 2-entry in-order request FIFO, per-destination
// queue credits, and a two-cycle atomic (CAS) pair sequencer feeding the PQ/PA stages.
module spc_pcx_req_issue #(
  parameter int NDEST   = 5,
  parameter int PKTW    = 124,
  parameter int CREDITS = 2
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [NDEST-1:0] req_dest,
  input  logic             req_atom,
  input  logic [PKTW-1:0]  req_data,
  input  logic [NDEST-1:0] pcx_spc_grant_pa,
  output logic [NDEST-1:0] spc_pcx_req_pq,
  output logic             spc_pcx_atom_pq,
  output logic [PKTW-1:0]  spc_pcx_data_pa,
  output logic             credit_err
);

  localparam int CW        = $clog2(CREDITS + 1);
  localparam int ATOM_COST = 2;

  typedef enum logic {ST_IDLE, ST_ATOM2} state_t;

  state_t            r_state;
  logic [PKTW-1:0]   r_fifo_data [2];
  logic [NDEST-1:0]  r_fifo_dest [2];
  logic              r_fifo_atom [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;
  logic [CW-1:0]     r_credit [NDEST];
  logic [NDEST-1:0]  r_atom_dest;
  logic [PKTW-1:0]   r_data_pa;
  logic              r_err;

  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic              w_cred_ok;
  logic              w_mismatch;
  logic [NDEST-1:0]  w_head_dest;
  logic              w_head_atom;
  logic [PKTW-1:0]   w_head_data;
  logic [NDEST-1:0]  w_issue_dest;
  logic [NDEST-1:0]  w_has_one;
  logic [NDEST-1:0]  w_is_full;
  logic [NDEST-1:0]  w_ovf;
  logic [CW-1:0]     w_dec [NDEST];
  logic [CW-1:0]     w_credit_next [NDEST];

  assign req_rdy     = (r_count != 2'd2);
  assign w_push      = req_vld & req_rdy;
  assign w_head_dest = r_fifo_dest[r_rd_ptr];
  assign w_head_atom = r_fifo_atom[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  // Issue decisions look only at registered credits, never at this cycle's grants.
  assign w_cred_ok = w_head_atom ? ((r_count == 2'd2) && |(w_head_dest & w_is_full))
                                 : |(w_head_dest & w_has_one);
  assign w_issue      = ~reset & (r_state == ST_IDLE) & (r_count != 2'd0) & w_cred_ok;
  assign w_issue_dest = w_issue ? w_head_dest : '0;
  assign w_pop        = w_issue | (r_state == ST_ATOM2);
  assign w_mismatch   = (r_state == ST_ATOM2) && (w_head_dest != r_atom_dest);

  generate
    for (genvar gi = 0; gi < NDEST; gi++) begin : g_dest
      assign w_has_one[gi] = (r_credit[gi] != '0);
      assign w_is_full[gi] = (r_credit[gi] == CW'(CREDITS));
      assign w_dec[gi]     = w_issue_dest[gi] ? (w_head_atom ? CW'(ATOM_COST) : CW'(1)) : '0;
      assign w_ovf[gi]     = pcx_spc_grant_pa[gi] & w_is_full[gi] & ~w_issue_dest[gi];
      assign w_credit_next[gi] = w_ovf[gi] ? r_credit[gi]
                               : r_credit[gi] - w_dec[gi] + CW'(pcx_spc_grant_pa[gi]);
    end
  endgenerate

  always_ff @(posedge rclk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= req_data;
      r_fifo_dest[r_wr_ptr] <= req_dest;
      r_fifo_atom[r_wr_ptr] <= req_atom;
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_atom_dest <= '0;
      r_data_pa   <= '0;
      r_err       <= 1'b0;
      for (int i = 0; i < NDEST; i++) r_credit[i] <= CW'(CREDITS);
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count   <= r_count + 2'(w_push) - 2'(w_pop);
      r_data_pa <= w_pop ? w_head_data : '0;
      r_err     <= r_err | (|w_ovf) | w_mismatch;
      for (int i = 0; i < NDEST; i++) r_credit[i] <= w_credit_next[i];
      case (r_state)
        ST_IDLE: begin
          if (w_issue && w_head_atom) begin
            r_state     <= ST_ATOM2;
            r_atom_dest <= w_head_dest;
          end
        end
        ST_ATOM2: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign spc_pcx_req_pq  = w_issue_dest;
  assign spc_pcx_atom_pq = w_issue & w_head_atom;
  assign spc_pcx_data_pa = r_data_pa;
  assign credit_err      = r_err;

endmodule

// File: tb/tb_spc_pcx_req_issue.sv
// Directed bench for spc_pcx_req_issue: a queue/credit-count model checked every
// cycle, plus hand-computed literal expectations at key cycles.
module tb_spc_pcx_req_issue;

  localparam int NDEST   = 5;
  localparam int PKTW    = 124;
  localparam int CREDITS = 2;

  logic             rclk = 1'b0;
  logic             reset = 1'b1;
  logic             req_vld = 1'b0;
  logic             req_rdy;
  logic [NDEST-1:0] req_dest = '0;
  logic             req_atom = 1'b0;
  logic [PKTW-1:0]  req_data = '0;
  logic [NDEST-1:0] grant = '0;
  logic [NDEST-1:0] spc_pcx_req_pq;
  logic             spc_pcx_atom_pq;
  logic [PKTW-1:0]  spc_pcx_data_pa;
  logic             credit_err;

  int n_vec = 0;
  int n_err = 0;

  spc_pcx_req_issue #(.NDEST(NDEST), .PKTW(PKTW), .CREDITS(CREDITS)) dut (
    .rclk             (rclk),
    .reset            (reset),
    .req_vld          (req_vld),
    .req_rdy          (req_rdy),
    .req_dest         (req_dest),
    .req_atom         (req_atom),
    .req_data         (req_data),
    .pcx_spc_grant_pa (grant),
    .spc_pcx_req_pq   (spc_pcx_req_pq),
    .spc_pcx_atom_pq  (spc_pcx_atom_pq),
    .spc_pcx_data_pa  (spc_pcx_data_pa),
    .credit_err       (credit_err)
  );

  always #5 rclk = ~rclk;

  task automatic cmp(input string nm, input logic [PKTW-1:0] act, input logic [PKTW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the FIFO is a queue of packets, credits are plain integers.
  typedef struct {
    logic [NDEST-1:0] dest;
    logic             atom;
    logic [PKTW-1:0]  data;
  } pkt_t;

  pkt_t             mq[$];
  int               mcred[NDEST];
  bit               m_second = 0;
  logic [NDEST-1:0] m_first_dest = '0;
  logic [PKTW-1:0]  m_data_exp = '0;
  bit               m_err = 0;
  bit               m_live = 0;

  function automatic int idx(input logic [NDEST-1:0] d);
    for (int i = 0; i < NDEST; i++) if (d[i]) return i;
    return 0;
  endfunction

  always @(negedge rclk) begin
    pkt_t             h;
    bit               ok;
    bit               e_rdy;
    logic [NDEST-1:0] e_req;
    logic             e_atom;
    logic [PKTW-1:0]  nd;
    int               dec;
    ok = 0; e_req = '0; e_atom = 1'b0; nd = '0;
    h.dest = '0; h.atom = 1'b0; h.data = '0;
    e_rdy = (mq.size() < 2);
    if (m_live && !m_second && mq.size() > 0) begin
      h = mq[0];
      if (h.atom) ok = (mq.size() >= 2) && (mcred[idx(h.dest)] == 2);
      else        ok = (mcred[idx(h.dest)] >= 1);
    end
    if (ok) begin
      e_req  = h.dest;
      e_atom = h.atom;
    end
    if (m_live && !reset) begin
      cmp("req_pq",  PKTW'(spc_pcx_req_pq),  PKTW'(e_req));
      cmp("atom_pq", PKTW'(spc_pcx_atom_pq), PKTW'(e_atom));
      cmp("data_pa", spc_pcx_data_pa,        m_data_exp);
      cmp("req_rdy", PKTW'(req_rdy),         PKTW'(e_rdy));
      cmp("cred_err", PKTW'(credit_err),     PKTW'(m_err));
      if (ok) $display("issue dest=%b atom=%b data=%h", e_req, e_atom, h.data);
    end
    if (reset) begin
      mq.delete();
      for (int d = 0; d < NDEST; d++) mcred[d] = CREDITS;
      m_second   = 0;
      m_data_exp = '0;
      m_err      = 0;
      m_live     = 1;
    end else if (m_live) begin
      if (m_second) begin
        pkt_t s;
        s  = mq.pop_front();
        nd = s.data;
        if (s.dest != m_first_dest) m_err = 1;
        m_second = 0;
      end else if (ok) begin
        void'(mq.pop_front());
        nd = h.data;
        if (h.atom) begin
          m_second     = 1;
          m_first_dest = h.dest;
        end
      end
      for (int d = 0; d < NDEST; d++) begin
        dec = (ok && h.dest[d]) ? (h.atom ? 2 : 1) : 0;
        if (grant[d]) begin
          if (mcred[d] == CREDITS && dec == 0) m_err = 1;
          else mcred[d] = mcred[d] + 1 - dec;
        end else begin
          mcred[d] = mcred[d] - dec;
        end
      end
      if (req_vld && e_rdy) begin
        pkt_t p;
        p.dest = req_dest; p.atom = req_atom; p.data = req_data;
        mq.push_back(p);
      end
      m_data_exp = nd;
    end
  end

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic drive(input logic [NDEST-1:0] d, input logic a, input logic [PKTW-1:0] data);
    req_vld = 1'b1; req_dest = d; req_atom = a; req_data = data;
  endtask

  task automatic idle();
    req_vld = 1'b0; req_dest = '0; req_atom = 1'b0; req_data = '0;
  endtask

  function automatic logic [PKTW-1:0] pk(input logic [30:0] n);
    return {n, ~n, n, n ^ 31'h2a5a5a5a};
  endfunction

  task automatic chk(input string nm, input logic [PKTW-1:0] act, input logic [PKTW-1:0] exp);
    cmp(nm, act, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst_rdy",  PKTW'(req_rdy), 1);
    chk("rst_req",  PKTW'(spc_pcx_req_pq), 0);
    chk("rst_data", spc_pcx_data_pa, 0);
    chk("rst_err",  PKTW'(credit_err), 0);

    // single load to bank0, then a grant returns its credit
    drive(5'b00001, 1'b0, pk(1)); step(); idle();
    chk("t1_req", PKTW'(spc_pcx_req_pq), PKTW'(5'b00001));
    step();
    chk("t1_data", spc_pcx_data_pa, pk(1));
    chk("t1_req0", PKTW'(spc_pcx_req_pq), 0);
    grant = 5'b00001; step(); grant = '0;
    chk("t1_err", PKTW'(credit_err), 0);

    // three packets to bank2: two go, third waits for a grant
    drive(5'b00100, 1'b0, pk(2)); step();
    chk("t2_req_a", PKTW'(spc_pcx_req_pq), PKTW'(5'b00100));
    drive(5'b00100, 1'b0, pk(3)); step();
    chk("t2_req_b", PKTW'(spc_pcx_req_pq), PKTW'(5'b00100));
    chk("t2_data_a", spc_pcx_data_pa, pk(2));
    drive(5'b00100, 1'b0, pk(4)); step(); idle();
    chk("t2_stall", PKTW'(spc_pcx_req_pq), 0);
    chk("t2_data_b", spc_pcx_data_pa, pk(3));
    step();
    chk("t2_stall2", PKTW'(spc_pcx_req_pq), 0);
    grant = 5'b00100; step(); grant = '0;
    chk("t2_req_c", PKTW'(spc_pcx_req_pq), PKTW'(5'b00100));
    step();
    chk("t2_data_c", spc_pcx_data_pa, pk(4));
    grant = 5'b00100; step(); step(); grant = '0;

    // CAS pair to bank1 with full credit
    drive(5'b00010, 1'b1, pk(5)); step();
    chk("t3_wait_half2", PKTW'(spc_pcx_req_pq), 0);
    drive(5'b00010, 1'b0, pk(6)); step(); idle();
    chk("t3_req", PKTW'(spc_pcx_req_pq), PKTW'(5'b00010));
    chk("t3_atom", PKTW'(spc_pcx_atom_pq), 1);
    step();
    chk("t3_noreq", PKTW'(spc_pcx_req_pq), 0);
    chk("t3_half1", spc_pcx_data_pa, pk(5));
    step();
    chk("t3_half2", spc_pcx_data_pa, pk(6));
    step();
    chk("t3_data0", spc_pcx_data_pa, 0);
    grant = 5'b00010; step(); step(); grant = '0;

    // CAS with one credit blocks, and a younger bank3 packet waits behind it
    drive(5'b00010, 1'b0, pk(7)); step();
    drive(5'b00010, 1'b1, pk(8)); step();
    drive(5'b00010, 1'b0, pk(9)); step();
    drive(5'b01000, 1'b0, pk(10));
    chk("t4_blk_req", PKTW'(spc_pcx_req_pq), 0);
    chk("t4_blk_rdy", PKTW'(req_rdy), 0);
    step();
    chk("t4_blk_req2", PKTW'(spc_pcx_req_pq), 0);
    step();
    grant = 5'b00010; step(); grant = '0;
    chk("t4_req", PKTW'(spc_pcx_req_pq), PKTW'(5'b00010));
    chk("t4_atom", PKTW'(spc_pcx_atom_pq), 1);
    step();
    chk("t4_noreq", PKTW'(spc_pcx_req_pq), 0);
    chk("t4_half1", spc_pcx_data_pa, pk(8));
    step(); idle();
    chk("t4_young", PKTW'(spc_pcx_req_pq), PKTW'(5'b01000));
    chk("t4_half2", spc_pcx_data_pa, pk(9));
    step();
    chk("t4_ydata", spc_pcx_data_pa, pk(10));
    grant = 5'b01010; step(); grant = 5'b00010; step(); grant = '0;

    // grant in the issue cycle nets out; grant at full credit flags an error
    drive(5'b00001, 1'b0, pk(11)); step(); idle();
    grant = 5'b00001;
    chk("t5_req", PKTW'(spc_pcx_req_pq), PKTW'(5'b00001));
    step(); grant = '0;
    chk("t5_err0", PKTW'(credit_err), 0);
    grant = 5'b00001; step(); grant = '0;
    chk("t5_err1", PKTW'(credit_err), 1);
    step();
    chk("t5_sticky", PKTW'(credit_err), 1);

    // reset while the second CAS half is pending
    drive(5'b00100, 1'b1, pk(12)); step();
    drive(5'b00100, 1'b0, pk(13)); step(); idle();
    chk("t6_req", PKTW'(spc_pcx_req_pq), PKTW'(5'b00100));
    step();
    chk("t6_half1", spc_pcx_data_pa, pk(12));
    reset = 1'b1; step(); reset = 1'b0;
    chk("t6_req0",  PKTW'(spc_pcx_req_pq), 0);
    chk("t6_data0", spc_pcx_data_pa, 0);
    chk("t6_rdy",   PKTW'(req_rdy), 1);
    chk("t6_err0",  PKTW'(credit_err), 0);
    step();
    chk("t6_empty", PKTW'(spc_pcx_req_pq), 0);

    // CAS whose halves target different banks still goes out but flags an error
    drive(5'b00100, 1'b1, pk(14)); step();
    drive(5'b01000, 1'b0, pk(15)); step(); idle();
    chk("t7_req", PKTW'(spc_pcx_req_pq), PKTW'(5'b00100));
    step();
    chk("t7_err0", PKTW'(credit_err), 0);
    step();
    chk("t7_half2", spc_pcx_data_pa, pk(15));
    chk("t7_err1", PKTW'(credit_err), 1);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
